// File: rtl/touch_key_pkg.sv
// Shared constants and helpers for the touch-key front end.
// The optional long-press feature is enabled by defining TOUCH_KEY_LONG_PRESS_EN.
package touch_key_pkg;

   localparam int   CH_NUM_MAX = 16;
   localparam logic LVL_ACTIVE = 1'b1;
   localparam logic LVL_IDLE   = 1'b0;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/touch_key_chan.sv
// One touch channel: 2-flop synchroniser, debounce, press edge and optional hold counter.
// Long-press detection is compiled in only when TOUCH_KEY_LONG_PRESS_EN is defined.
module touch_key_chan
   import touch_key_pkg::*;
#(
   parameter int   DEB_CYC    = 1_000_000,
   parameter logic ACTIVE_LVL = 1'b0,
   parameter int   LONG_CYC   = 50_000_000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic touch_i,
   output logic key_state_o,
   output logic press_set_o,
   output logic press_pulse_o,
   output logic long_set_o,
   output logic long_pulse_o
);

   localparam int CW = cnt_width(DEB_CYC);

   logic          sync1_q;
   logic          sync2_q;
   logic          norm_s;
   logic [CW-1:0] deb_cnt_q;
   logic [CW-1:0] deb_cnt_d;
   logic          state_q;
   logic          state_d;
   logic          press_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync1_q <= ~ACTIVE_LVL;
         sync2_q <= ~ACTIVE_LVL;
      end else begin
         sync1_q <= touch_i;
         sync2_q <= sync1_q;
      end
   end

   assign norm_s = (sync2_q == ACTIVE_LVL) ? LVL_ACTIVE : LVL_IDLE;

   // Accept a new level only after DEB_CYC consecutive disagreeing cycles.
   always_comb begin
      deb_cnt_d = '0;
      state_d   = state_q;
      if (norm_s == state_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == CW'(DEB_CYC - 1)) begin
         state_d   = norm_s;
         deb_cnt_d = '0;
      end else begin
         deb_cnt_d = deb_cnt_q + CW'(1);
      end
   end

   assign press_set_o = state_d & ~state_q;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         deb_cnt_q <= '0;
         state_q   <= 1'b0;
         press_q   <= 1'b0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
         state_q   <= state_d;
         press_q   <= press_set_o;
      end
   end

   assign key_state_o   = state_q;
   assign press_pulse_o = press_q;

`ifdef TOUCH_KEY_LONG_PRESS_EN
   localparam int HW = cnt_width(LONG_CYC + 1);

   logic [HW-1:0] hold_q;
   logic [HW-1:0] hold_d;
   logic          long_q;

   // Hold counter saturates at LONG_CYC so the strobe cannot repeat while held.
   always_comb begin
      hold_d = hold_q;
      if (!state_q) begin
         hold_d = '0;
      end else if (hold_q != HW'(LONG_CYC)) begin
         hold_d = hold_q + HW'(1);
      end else begin
         hold_d = hold_q;
      end
   end

   assign long_set_o = state_q & (hold_q == HW'(LONG_CYC - 1));

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_set_o;
      end
   end

   assign long_pulse_o = long_q;
`else
   logic unused_long_s;
   assign unused_long_s = (LONG_CYC > DEB_CYC);
   assign long_set_o    = 1'b0;
   assign long_pulse_o  = 1'b0;
`endif

endmodule

// File: rtl/touch_key_array.sv
// Multi-channel touch-key front end with per-channel toggle/momentary LED drive.
// Define TOUCH_KEY_LONG_PRESS_EN to enable long-press strobes and LED clear.
module touch_key_array
   import touch_key_pkg::*;
#(
   parameter int   CH_NUM     = 4,
   parameter int   DEB_CYC    = 1_000_000,
   parameter logic ACTIVE_LVL = 1'b0,
   parameter int   LONG_CYC   = 50_000_000
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [CH_NUM-1:0] touch_key,
   input  logic [CH_NUM-1:0] mode_toggle,
   output logic [CH_NUM-1:0] press_pulse,
   output logic [CH_NUM-1:0] key_state,
   output logic [CH_NUM-1:0] led_out,
   output logic [CH_NUM-1:0] long_pulse
);

   logic [CH_NUM-1:0] key_s;
   logic [CH_NUM-1:0] press_set_s;
   logic [CH_NUM-1:0] press_s;
   logic [CH_NUM-1:0] long_set_s;
   logic [CH_NUM-1:0] long_s;
   logic [CH_NUM-1:0] led_q;
   logic [CH_NUM-1:0] led_d;

   for (genvar g = 0; g < CH_NUM; g++) begin : g_chan
      touch_key_chan #(
         .DEB_CYC    (DEB_CYC),
         .ACTIVE_LVL (ACTIVE_LVL),
         .LONG_CYC   (LONG_CYC)
      ) u_chan (
         .sys_clk       (sys_clk),
         .sys_rst_n     (sys_rst_n),
         .touch_i       (touch_key[g]),
         .key_state_o   (key_s[g]),
         .press_set_o   (press_set_s[g]),
         .press_pulse_o (press_s[g]),
         .long_set_o    (long_set_s[g]),
         .long_pulse_o  (long_s[g])
      );
   end

   // Toggle mode flips on the press edge (a long press clears); momentary mode tracks key_state.
   always_comb begin
      led_d = led_q;
      for (int i = 0; i < CH_NUM; i++) begin
         if (mode_toggle[i]) begin
            if (long_set_s[i]) begin
               led_d[i] = 1'b0;
            end else if (press_set_s[i]) begin
               led_d[i] = ~led_q[i];
            end else begin
               led_d[i] = led_q[i];
            end
         end else begin
            led_d[i] = key_s[i];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         led_q <= '0;
      end else begin
         led_q <= led_d;
      end
   end

   assign press_pulse = press_s;
   assign key_state   = key_s;
   assign led_out     = led_q;
   assign long_pulse  = long_s;

endmodule

// File: tb/tb_touch_key_array.sv
// Directed bench for touch_key_array: CH_NUM=4, DEB_CYC=4, LONG_CYC=20, 50 MHz clock.
module tb_touch_key_array;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [3:0] touch_key;
   logic [3:0] mode_toggle;
   logic [3:0] press_pulse;
   logic [3:0] key_state;
   logic [3:0] led_out;
   logic [3:0] long_pulse;

   int n_cmp = 0;
   int n_mis = 0;

   touch_key_array #(
      .CH_NUM     (4),
      .DEB_CYC    (4),
      .ACTIVE_LVL (1'b0),
      .LONG_CYC   (20)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .touch_key   (touch_key),
      .mode_toggle (mode_toggle),
      .press_pulse (press_pulse),
      .key_state   (key_state),
      .led_out     (led_out),
      .long_pulse  (long_pulse)
   );

   always #10 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   function automatic logic [15:0] outs();
      return {long_pulse, led_out, key_state, press_pulse};
   endfunction

   initial begin
      // 1. reset with pads idle (high)
      sys_rst_n   = 1'b0;
      touch_key   = 4'hF;
      mode_toggle = 4'h0;
      #25;
      chk("reset_outs", 32'(outs()), 32'h0);
      #15;
      sys_rst_n = 1'b1;
      for (int c = 1; c <= 100; c++) begin
         step();
         chk($sformatf("idle c%0d", c), 32'(outs()), 32'h0);
      end

      // 2. 3-cycle glitch on ch0 is rejected
      mode_toggle  = 4'hF;
      touch_key[0] = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         step();
         if (c == 3) touch_key[0] = 1'b1;
         chk($sformatf("glitch c%0d", c), 32'(outs()), 32'h0);
      end

      // 3. toggle mode on ch0: low 10, high 10, low 10
      touch_key[0] = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         step();
         chk($sformatf("t3_press c%0d", c), 32'(press_pulse), (c == 6 || c == 26) ? 32'h1 : 32'h0);
         chk($sformatf("t3_led0 c%0d", c), 32'(led_out[0]), (c >= 6 && c < 26) ? 32'h1 : 32'h0);
         if (c == 10) touch_key[0] = 1'b1;
         if (c == 20) touch_key[0] = 1'b0;
         if (c == 30) touch_key[0] = 1'b1;
      end

      // 4. momentary ch1, then switch to toggle
      mode_toggle  = 4'b1101;
      touch_key[1] = 1'b0;
      for (int c = 1; c <= 25; c++) begin
         step();
         chk($sformatf("t4_press c%0d", c), 32'(press_pulse), (c == 6) ? 32'h2 : 32'h0);
         chk($sformatf("t4_key1 c%0d", c), 32'(key_state[1]), (c >= 6 && c < 16) ? 32'h1 : 32'h0);
         chk($sformatf("t4_led1 c%0d", c), 32'(led_out[1]), (c >= 7 && c < 17) ? 32'h1 : 32'h0);
         if (c == 10) touch_key[1] = 1'b1;
      end
      mode_toggle = 4'hF;
      for (int c = 1; c <= 10; c++) begin
         step();
         chk($sformatf("t4_hold c%0d", c), 32'(led_out[1]), 32'h0);
      end
      touch_key[1] = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         step();
         chk($sformatf("t4_tog c%0d", c), 32'(led_out[1]), (c >= 6) ? 32'h1 : 32'h0);
         if (c == 8) touch_key[1] = 1'b1;
      end

      // 5. simultaneous press on ch2 and ch3
      touch_key[3:2] = 2'b00;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk($sformatf("t5_press c%0d", c), 32'(press_pulse), (c == 6) ? 32'hC : 32'h0);
         chk($sformatf("t5_led c%0d", c), 32'(led_out), (c >= 6) ? 32'hE : 32'h2);
         if (c == 10) touch_key[3:2] = 2'b11;
      end

      // 6a. reset asserted at debounce count 2
      touch_key[0] = 1'b0;
      for (int c = 1; c <= 4; c++) step();
      sys_rst_n = 1'b0;
      #1;
      chk("t6_in_reset", 32'(outs()), 32'h0);
      step();
      step();
      touch_key[0] = 1'b1;
      sys_rst_n    = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         step();
         chk($sformatf("t6_after_rst c%0d", c), 32'(outs()), 32'h0);
      end

      // 6b. hold ch0 for 30 cycles in toggle mode
      touch_key[0] = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         step();
         chk($sformatf("t6_press c%0d", c), 32'(press_pulse), (c == 6) ? 32'h1 : 32'h0);
         chk($sformatf("t6_key c%0d", c), 32'(key_state), (c >= 6 && c < 36) ? 32'h1 : 32'h0);
`ifdef TOUCH_KEY_LONG_PRESS_EN
         chk($sformatf("t6_long c%0d", c), 32'(long_pulse), (c == 26) ? 32'h1 : 32'h0);
         chk($sformatf("t6_led c%0d", c), 32'(led_out), (c >= 6 && c < 26) ? 32'h1 : 32'h0);
`else
         chk($sformatf("t6_long c%0d", c), 32'(long_pulse), 32'h0);
         chk($sformatf("t6_led c%0d", c), 32'(led_out), (c >= 6) ? 32'h1 : 32'h0);
`endif
         if (c == 30) touch_key[0] = 1'b1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
